// File: rtl/riscv_pkg.sv
// Shared RV32I core types: decoder control bundle, result-source encodings, opcodes.
package riscv_pkg;

  localparam int ALUCTRL_W = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic                 regWrite;
    logic                 memWrite;
    logic                 jump;
    logic                 branch;
    logic                 aluSrc;
    logic [ALUCTRL_W-1:0] aluControl;
    logic [1:0]           resultSrc;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// D-stage inputs, E-stage register outputs and stall/flush controls of the ID/EX boundary.
interface id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) ();

  logic              validD;
  riscv_pkg::ctrl_t  ctrlD;
  logic [2:0]        funct3D;
  logic [4:0]        rs1D, rs2D, rdD;
  logic [XLEN-1:0]   rd1D, rd2D, immExtD, pcD, pcPlus4D;
  logic              pcSrcE;
  logic              memBusyM;

  riscv_pkg::ctrl_t  ctrlE;
  logic [2:0]        funct3E;
  logic [4:0]        rs1E, rs2E, rdE;
  logic [XLEN-1:0]   rd1E, rd2E, immExtE, pcE, pcPlus4E;
  logic              validE;
  logic              stallF, stallD, flushD;
  logic [CNT_W-1:0]  bubbleCnt, flushCnt;

  modport master (
    output validD, ctrlD, funct3D, rs1D, rs2D, rdD, rd1D, rd2D, immExtD, pcD, pcPlus4D,
           pcSrcE, memBusyM,
    input  ctrlE, funct3E, rs1E, rs2E, rdE, rd1E, rd2E, immExtE, pcE, pcPlus4E, validE,
           stallF, stallD, flushD, bubbleCnt, flushCnt
  );

  modport slave (
    input  validD, ctrlD, funct3D, rs1D, rs2D, rdD, rd1D, rd2D, immExtD, pcD, pcPlus4D,
           pcSrcE, memBusyM,
    output ctrlE, funct3E, rs1E, rs2E, rdE, rd1E, rd2E, immExtE, pcE, pcPlus4E, validE,
           stallF, stallD, flushD, bubbleCnt, flushCnt
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use detector: a load in E whose destination is read by the instruction in D.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic       i_validD,
  input  logic [4:0] i_rs1D,
  input  logic [4:0] i_rs2D,
  input  logic       i_validE,
  input  logic       i_regWriteE,
  input  logic [1:0] i_resultSrcE,
  input  logic [4:0] i_rdE,
  output logic       o_load_use
);

  logic w_e_is_load;
  logic w_src_match;

  assign w_e_is_load = i_validE & i_regWriteE & (i_resultSrcE == RES_MEM) & (i_rdE != 5'd0);
  // rs2 is compared even for formats without rs2; a spurious bubble is harmless
  assign w_src_match = (i_rdE == i_rs1D) | (i_rdE == i_rs2D);
  assign o_load_use  = w_e_is_load & i_validD & w_src_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush priority (mem busy > redirect > load-use)
// and saturating bubble/flush performance counters.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.slave  bus
);

  logic w_load_use;
  logic w_stall;
  logic w_flush;
  logic w_take_d;
  logic w_lu_bubble;

  ctrl_t            r_ctrl;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0]  r_rd1, r_rd2, r_imm, r_pc, r_pc4;
  logic             r_valid;
  logic [CNT_W-1:0] r_bubble_cnt, r_flush_cnt;

  hazard_detect u_hazard (
    .i_validD     (bus.validD),
    .i_rs1D       (bus.rs1D),
    .i_rs2D       (bus.rs2D),
    .i_validE     (r_valid),
    .i_regWriteE  (r_ctrl.regWrite),
    .i_resultSrcE (r_ctrl.resultSrc),
    .i_rdE        (r_rd),
    .o_load_use   (w_load_use)
  );

  always_comb begin
    w_stall = 1'b0;
    w_flush = 1'b0;
    if (bus.memBusyM) begin
      w_stall = 1'b1;
    end else if (bus.pcSrcE) begin
      w_flush = 1'b1;
    end else if (w_load_use) begin
      w_stall = 1'b1;
    end
  end

  assign w_lu_bubble = w_stall & ~bus.memBusyM;
  assign w_take_d    = ~bus.memBusyM & ~w_flush & ~w_stall & bus.validD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl   <= '0;
      r_funct3 <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
      r_pc4    <= '0;
      r_valid  <= 1'b0;
    end else if (!bus.memBusyM) begin
      // Data fields follow D even into a bubble; only control and valid are squashed
      r_funct3 <= bus.funct3D;
      r_rs1    <= bus.rs1D;
      r_rs2    <= bus.rs2D;
      r_rd     <= bus.rdD;
      r_rd1    <= bus.rd1D;
      r_rd2    <= bus.rd2D;
      r_imm    <= bus.immExtD;
      r_pc     <= bus.pcD;
      r_pc4    <= bus.pcPlus4D;
      r_valid  <= w_take_d;
      r_ctrl   <= w_take_d ? bus.ctrlD : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_lu_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ctrlE     = r_ctrl;
  assign bus.funct3E   = r_funct3;
  assign bus.rs1E      = r_rs1;
  assign bus.rs2E      = r_rs2;
  assign bus.rdE       = r_rd;
  assign bus.rd1E      = r_rd1;
  assign bus.rd2E      = r_rd2;
  assign bus.immExtE   = r_imm;
  assign bus.pcE       = r_pc;
  assign bus.pcPlus4E  = r_pc4;
  assign bus.validE    = r_valid;
  assign bus.stallF    = w_stall;
  assign bus.stallD    = w_stall;
  assign bus.flushD    = w_flush;
  assign bus.bubbleCnt = r_bubble_cnt;
  assign bus.flushCnt  = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table, hand sequences and random traffic against a cycle model.
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam int CNT_S = 2;
  localparam int CW    = $bits(ctrl_t);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_S)) bus_s ();

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_S)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  // small-counter copy sees identical stimulus so saturation is reachable quickly
  assign bus_s.validD   = bus.validD;
  assign bus_s.ctrlD    = bus.ctrlD;
  assign bus_s.funct3D  = bus.funct3D;
  assign bus_s.rs1D     = bus.rs1D;
  assign bus_s.rs2D     = bus.rs2D;
  assign bus_s.rdD      = bus.rdD;
  assign bus_s.rd1D     = bus.rd1D;
  assign bus_s.rd2D     = bus.rd2D;
  assign bus_s.immExtD  = bus.immExtD;
  assign bus_s.pcD      = bus.pcD;
  assign bus_s.pcPlus4D = bus.pcPlus4D;
  assign bus_s.pcSrcE   = bus.pcSrcE;
  assign bus_s.memBusyM = bus.memBusyM;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc;
    logic        pcsrc, busy;
  } d_in_t;

  typedef struct {
    logic       e_rw;
    logic [1:0] e_rs;
    logic [4:0] e_rd;
    logic       d_v;
    logic [4:0] d_rs1, d_rs2;
    logic       pcsrc, busy;
    logic       x_stall, x_flush, x_valid;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: what sits in E, plus unbounded event counts
  d_in_t  m_e;
  logic   m_valid;
  longint m_bcnt, m_fcnt;
  logic   obs_stall, obs_flush;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkw(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint c, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  function automatic d_in_t mk(input logic v, input logic rw, input logic [1:0] rs,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic pcsrc, input logic busy);
    d_in_t d;
    d.valid          = v;
    d.ctrl           = ctrl_t'(CW'($urandom));
    d.ctrl.regWrite  = rw;
    d.ctrl.resultSrc = rs;
    d.f3             = 3'($urandom);
    d.rs1            = rs1;
    d.rs2            = rs2;
    d.rd             = rd;
    d.rd1            = $urandom;
    d.rd2            = $urandom;
    d.imm            = $urandom;
    d.pc             = $urandom & 32'hFFFF_FFFC;
    d.pcsrc          = pcsrc;
    d.busy           = busy;
    return d;
  endfunction

  function automatic logic [255:0] fields(input d_in_t d);
    return 256'({d.ctrl, d.f3, d.rs1, d.rs2, d.rd, d.rd1, d.rd2, d.imm, d.pc, d.pc + 32'd4});
  endfunction

  task automatic drive(input d_in_t d);
    bus.validD   = d.valid;
    bus.ctrlD    = d.ctrl;
    bus.funct3D  = d.f3;
    bus.rs1D     = d.rs1;
    bus.rs2D     = d.rs2;
    bus.rdD      = d.rd;
    bus.rd1D     = d.rd1;
    bus.rd2D     = d.rd2;
    bus.immExtD  = d.imm;
    bus.pcD      = d.pc;
    bus.pcPlus4D = d.pc + 32'd4;
    bus.pcSrcE   = d.pcsrc;
    bus.memBusyM = d.busy;
  endtask

  task automatic model_reset();
    m_e     = '0;
    m_valid = 1'b0;
    m_bcnt  = 0;
    m_fcnt  = 0;
  endtask

  task automatic check_e();
    logic [255:0] act_f;
    act_f = 256'({bus.ctrlE, bus.funct3E, bus.rs1E, bus.rs2E, bus.rdE, bus.rd1E, bus.rd2E,
                  bus.immExtE, bus.pcE, bus.pcPlus4E});
    check1("validE", bus.validE, m_valid);
    check1("validE_small", bus_s.validE, m_valid);
    checkw("ctrl_flags",
           256'({bus.ctrlE.regWrite, bus.ctrlE.memWrite, bus.ctrlE.jump, bus.ctrlE.branch}),
           m_valid ? 256'({m_e.ctrl.regWrite, m_e.ctrl.memWrite, m_e.ctrl.jump, m_e.ctrl.branch})
                   : 256'(0));
    if (m_valid) checkw("e_fields", act_f, fields(m_e));
    checkw("bubbleCnt", 256'(bus.bubbleCnt), 256'(sat(m_bcnt, CNT_W)));
    checkw("flushCnt", 256'(bus.flushCnt), 256'(sat(m_fcnt, CNT_W)));
    checkw("bubbleCnt_small", 256'(bus_s.bubbleCnt), 256'(sat(m_bcnt, CNT_S)));
    checkw("flushCnt_small", 256'(bus_s.flushCnt), 256'(sat(m_fcnt, CNT_S)));
  endtask

  // one clock: drive at negedge, check stall/flush, predict, check E at next negedge
  task automatic cycle(input d_in_t d);
    logic lu, x_stall, x_flush;
    drive(d);
    #1;
    lu = m_valid && m_e.ctrl.regWrite && (m_e.ctrl.resultSrc == RES_MEM) && (m_e.rd != 5'd0) &&
         d.valid && ((m_e.rd == d.rs1) || (m_e.rd == d.rs2));
    x_stall = 1'b0;
    x_flush = 1'b0;
    if (d.busy) begin
      x_stall = 1'b1;
    end else if (d.pcsrc) begin
      x_flush = 1'b1;
      m_fcnt++;
      m_valid = 1'b0;
    end else if (lu) begin
      x_stall = 1'b1;
      m_bcnt++;
      m_valid = 1'b0;
    end else begin
      m_e     = d;
      m_valid = d.valid;
    end
    obs_stall = bus.stallF;
    obs_flush = bus.flushD;
    check1("stallF", bus.stallF, x_stall);
    check1("stallD", bus.stallD, x_stall);
    check1("flushD", bus.flushD, x_flush);
    check1("stallF_small", bus_s.stallF, x_stall);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_e();
    $display("cyc %0d vD=%b rs1=%0d rs2=%0d rd=%0d pcsrc=%b busy=%b stall=%b flush=%b validE=%b bcnt=%0d fcnt=%0d",
             cyc, d.valid, d.rs1, d.rs2, d.rd, d.pcsrc, d.busy, obs_stall, obs_flush,
             bus.validE, bus.bubbleCnt, bus.flushCnt);
  endtask

  vec_t   tbl [12];
  d_in_t  d, ld, add;
  longint b0, f0;

  initial begin
    tbl[0]  = '{1'b1, RES_MEM, 5'd5, 1'b1, 5'd5, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, RES_MEM, 5'd5, 1'b1, 5'd9, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, RES_MEM, 5'd0, 1'b1, 5'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, RES_ALU, 5'd5, 1'b1, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, RES_MEM, 5'd5, 1'b0, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, RES_MEM, 5'd5, 1'b1, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, RES_MEM, 5'd5, 1'b1, 5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, RES_MEM, 5'd5, 1'b1, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, RES_MEM, 5'd5, 1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, RES_PC4, 5'd5, 1'b1, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, RES_ALU, 5'd3, 1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, RES_MEM, 5'd5, 1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    drive('0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_validE", bus.validE, 1'b0);
    checkw("rst_bubbleCnt", 256'(bus.bubbleCnt), 256'(0));
    checkw("rst_flushCnt", 256'(bus.flushCnt), 256'(0));
    check1("rst_stallF", bus.stallF, 1'b0);
    check1("rst_flushD", bus.flushD, 1'b0);
    checkw("rst_ctrlE", 256'(bus.ctrlE), 256'(0));
    rst_n = 1'b1;

    // table: older instr loaded into E, then the probed D instr with redirect/busy
    for (int i = 0; i < 12; i++) begin
      cycle(mk(1'b0, 1'b0, RES_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
      cycle(mk(1'b1, tbl[i].e_rw, tbl[i].e_rs, tbl[i].e_rd, 5'd0, 5'd0, 1'b0, 1'b0));
      cycle(mk(tbl[i].d_v, 1'b1, RES_ALU, 5'd6, tbl[i].d_rs1, tbl[i].d_rs2, tbl[i].pcsrc, tbl[i].busy));
      check1($sformatf("tbl%0d_stall", i), obs_stall, tbl[i].x_stall);
      check1($sformatf("tbl%0d_flush", i), obs_flush, tbl[i].x_flush);
      check1($sformatf("tbl%0d_validE", i), bus.validE, tbl[i].x_valid);
    end

    // lw x5 then dependent add: one bubble, then add reaches E
    cycle(mk(1'b0, 1'b0, RES_ALU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0));
    b0  = m_bcnt;
    ld  = mk(1'b1, 1'b1, RES_MEM, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
    add = mk(1'b1, 1'b1, RES_ALU, 5'd6, 5'd5, 5'd2, 1'b0, 1'b0);
    cycle(ld);
    cycle(add);
    check1("lu_stall", obs_stall, 1'b1);
    check1("lu_bubble_validE", bus.validE, 1'b0);
    checkw("lu_bubbleCnt", 256'(bus.bubbleCnt), 256'(b0 + 1));
    cycle(add);
    check1("lu_release_stall", obs_stall, 1'b0);
    check1("lu_add_validE", bus.validE, 1'b1);
    checkw("lu_add_rdE", 256'(bus.rdE), 256'(6));

    // load to x0 never stalls
    b0 = m_bcnt;
    cycle(mk(1'b1, 1'b1, RES_MEM, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0));
    cycle(mk(1'b1, 1'b1, RES_ALU, 5'd6, 5'd0, 5'd2, 1'b0, 1'b0));
    check1("x0_stall", obs_stall, 1'b0);
    checkw("x0_bubbleCnt", 256'(bus.bubbleCnt), 256'(b0));

    // redirect beats a pending load-use
    b0 = m_bcnt;
    f0 = m_fcnt;
    cycle(ld);
    cycle(mk(1'b1, 1'b1, RES_ALU, 5'd6, 5'd5, 5'd2, 1'b1, 1'b0));
    check1("redir_flushD", obs_flush, 1'b1);
    check1("redir_stallD", obs_stall, 1'b0);
    check1("redir_validE", bus.validE, 1'b0);
    checkw("redir_flushCnt", 256'(bus.flushCnt), 256'(f0 + 1));
    checkw("redir_bubbleCnt", 256'(bus.bubbleCnt), 256'(b0));

    // taken branch held in E across 3 busy cycles, flush only once busy drops
    d = mk(1'b1, 1'b0, RES_ALU, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    d.ctrl.branch = 1'b1;
    cycle(d);
    f0 = m_fcnt;
    for (int k = 0; k < 3; k++) begin
      cycle(mk(1'b1, 1'b1, RES_ALU, 5'd7, 5'd3, 5'd4, 1'b1, 1'b1));
      check1($sformatf("busy%0d_flushD", k), obs_flush, 1'b0);
      check1($sformatf("busy%0d_branchE", k), bus.ctrlE.branch, 1'b1);
      checkw($sformatf("busy%0d_pcE", k), 256'(bus.pcE), 256'(d.pc));
    end
    cycle(mk(1'b1, 1'b1, RES_ALU, 5'd7, 5'd3, 5'd4, 1'b1, 1'b0));
    check1("busy_end_flushD", obs_flush, 1'b1);
    checkw("busy_end_flushCnt", 256'(bus.flushCnt), 256'(f0 + 1));
    cycle(mk(1'b1, 1'b1, RES_ALU, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0));
    check1("busy_after_flushD", obs_flush, 1'b0);

    // repeated load-use drives the 2-bit counter copy into saturation
    b0 = m_bcnt;
    for (int k = 0; k < 5; k++) begin
      cycle(ld);
      cycle(add);
    end
    checkw("sat_small_bubbleCnt", 256'(bus_s.bubbleCnt), 256'(3));
    checkw("sat_big_bubbleCnt", 256'(bus.bubbleCnt), 256'(b0 + 5));

    // asynchronous reset in the middle of a load-use stall
    cycle(ld);
    drive(add);
    #1;
    check1("pre_rst_stall", bus.stallF, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("async_rst_stallF", bus.stallF, 1'b0);
    check1("async_rst_validE", bus.validE, 1'b0);
    checkw("async_rst_bubbleCnt", 256'(bus.bubbleCnt), 256'(0));
    checkw("async_rst_flushCnt", 256'(bus.flushCnt), 256'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(add);
    check1("post_rst_validE", bus.validE, 1'b1);

    // random traffic with a narrow register range to provoke hazards
    for (int k = 0; k < 400; k++) begin
      d = mk($urandom_range(0, 9) < 8, 1'($urandom), 2'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15);
      cycle(d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
